// File: rtl/retimer_pos_neg_mc.sv
// Multi-channel pos/neg-edge retimer with handshaked, glitch-safe edge select
// and a shared transition monitor that helps firmware choose the sampling edge.
module retimer_pos_neg_mc #(
    parameter int NCH      = 4,
    parameter int MON_LOG2 = 6,
    parameter int TO_LOG2  = 4,
    parameter bit SEL_RST  = 1'b1
) (
    input  logic                        CK,
    input  logic                        NRST,
    input  logic [NCH-1:0]              D,
    input  logic [NCH-1:0]              POLARITY,
    input  logic [NCH-1:0]              POL_REQ,
    output logic [NCH-1:0]              POL_ACK,
    output logic [NCH-1:0]              POL_TO,
    output logic [NCH-1:0]              SEL,
    output logic [NCH-1:0]              OUT,
    input  logic                        MON_START,
    output logic                        MON_DONE,
    output logic [NCH*(MON_LOG2+1)-1:0] MON_CNT_A,
    output logic [NCH*(MON_LOG2+1)-1:0] MON_CNT_B
);
    localparam int CW = MON_LOG2 + 1;
    localparam logic [TO_LOG2-1:0]  TO_MAX  = '1;
    localparam logic [MON_LOG2-1:0] WIN_MAX = '1;

    typedef enum logic {P_IDLE, P_PEND} pol_state_e;
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mon_state_e;

    logic [NCH-1:0] d_pos_q, d_neg_q;
    logic [NCH-1:0] sel_q, pend_val_q, ack_q, to_q;
    logic [NCH-1:0] pend_nxt, safe;
    pol_state_e     pol_state_q [NCH];
    logic [TO_LOG2-1:0] timer_q [NCH];

    mon_state_e          mon_state_q;
    logic [MON_LOG2-1:0] win_cnt_q;
    logic                done_q;
    logic [NCH-1:0]      snap_neg_q, d_pos_dly_q;
    logic [NCH-1:0]      ev_a, ev_b;
    logic [CW-1:0]       cnt_a_q [NCH];
    logic [CW-1:0]       cnt_b_q [NCH];

    always_ff @(posedge CK or negedge NRST) begin
        if (!NRST) d_pos_q <= '0;
        else       d_pos_q <= D;
    end

    always_ff @(negedge CK or negedge NRST) begin
        if (!NRST) d_neg_q <= '0;
        else       d_neg_q <= D;
    end

    assign OUT = (sel_q & d_pos_q) | (~sel_q & d_neg_q);

    // Both samples low means neither path is mid-pulse, so the mux can move without a glitch.
    assign safe     = ~(d_pos_q | d_neg_q);
    assign pend_nxt = (POL_REQ & POLARITY) | (~POL_REQ & pend_val_q);

    always_ff @(posedge CK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < NCH; i++) begin
                pol_state_q[i] <= P_IDLE;
                timer_q[i]     <= '0;
            end
            sel_q      <= {NCH{SEL_RST}};
            pend_val_q <= '0;
            ack_q      <= '0;
            to_q       <= '0;
        end else begin
            ack_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                case (pol_state_q[i])
                    P_IDLE: begin
                        if (POL_REQ[i]) begin
                            pend_val_q[i] <= POLARITY[i];
                            to_q[i]       <= 1'b0;
                            timer_q[i]    <= '0;
                            if (POLARITY[i] == sel_q[i]) ack_q[i] <= 1'b1;
                            else                         pol_state_q[i] <= P_PEND;
                        end
                    end
                    P_PEND: begin
                        pend_val_q[i] <= pend_nxt[i];
                        if (safe[i] || (!POL_REQ[i] && timer_q[i] == TO_MAX)) begin
                            sel_q[i]       <= pend_nxt[i];
                            ack_q[i]       <= 1'b1;
                            to_q[i]        <= ~safe[i];
                            pol_state_q[i] <= P_IDLE;
                        end else begin
                            if (POL_REQ[i]) to_q[i] <= 1'b0;
                            timer_q[i] <= POL_REQ[i] ? '0 : timer_q[i] + 1'b1;
                        end
                    end
                    default: pol_state_q[i] <= P_IDLE;
                endcase
            end
        end
    end

    assign SEL     = sel_q;
    assign POL_ACK = ack_q;
    assign POL_TO  = to_q;

    // evA: change from a negedge sample to the next posedge sample; evB: posedge to next negedge.
    assign ev_a = d_pos_q ^ snap_neg_q;
    assign ev_b = snap_neg_q ^ d_pos_dly_q;

    always_ff @(posedge CK or negedge NRST) begin
        if (!NRST) begin
            mon_state_q <= M_IDLE;
            win_cnt_q   <= '0;
            done_q      <= 1'b0;
            snap_neg_q  <= '0;
            d_pos_dly_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_a_q[i] <= '0;
                cnt_b_q[i] <= '0;
            end
        end else begin
            snap_neg_q  <= d_neg_q;
            d_pos_dly_q <= d_pos_q;
            case (mon_state_q)
                M_RUN: begin
                    for (int i = 0; i < NCH; i++) begin
                        cnt_a_q[i] <= cnt_a_q[i] + {{(CW-1){1'b0}}, ev_a[i]};
                        cnt_b_q[i] <= cnt_b_q[i] + {{(CW-1){1'b0}}, ev_b[i]};
                    end
                    win_cnt_q <= win_cnt_q + 1'b1;
                    if (win_cnt_q == WIN_MAX) begin
                        mon_state_q <= M_DONE;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    if (MON_START) begin
                        for (int i = 0; i < NCH; i++) begin
                            cnt_a_q[i] <= '0;
                            cnt_b_q[i] <= '0;
                        end
                        win_cnt_q   <= '0;
                        done_q      <= 1'b0;
                        mon_state_q <= M_RUN;
                    end
                end
            endcase
        end
    end

    assign MON_DONE = done_q;

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign MON_CNT_A[g*CW +: CW] = cnt_a_q[g];
        assign MON_CNT_B[g*CW +: CW] = cnt_b_q[g];
    end

endmodule

// File: tb/tb_retimer_pos_neg_mc.sv
// Scoreboard bench: a sample-history reference model predicts acks, selects and
// monitor counts; a separate monitor process compares whenever the DUT presents them.
module tb_retimer_pos_neg_mc;
    localparam int NCH      = 4;
    localparam int MON_LOG2 = 6;
    localparam int TO_LOG2  = 4;
    localparam int CW       = MON_LOG2 + 1;
    localparam int WIN      = 1 << MON_LOG2;
    localparam int TO_CYC   = 1 << TO_LOG2;
    localparam int HLEN     = 8192;

    logic                CK = 1'b0;
    logic                NRST = 1'b0;
    logic [NCH-1:0]      D = '0;
    logic [NCH-1:0]      POLARITY = '0;
    logic [NCH-1:0]      POL_REQ = '0;
    logic                MON_START = 1'b0;
    logic [NCH-1:0]      POL_ACK, POL_TO, SEL, OUT;
    logic                MON_DONE;
    logic [NCH*CW-1:0]   MON_CNT_A, MON_CNT_B;

    retimer_pos_neg_mc #(.NCH(NCH), .MON_LOG2(MON_LOG2), .TO_LOG2(TO_LOG2), .SEL_RST(1'b1)) dut (
        .CK(CK), .NRST(NRST), .D(D), .POLARITY(POLARITY), .POL_REQ(POL_REQ),
        .POL_ACK(POL_ACK), .POL_TO(POL_TO), .SEL(SEL), .OUT(OUT),
        .MON_START(MON_START), .MON_DONE(MON_DONE),
        .MON_CNT_A(MON_CNT_A), .MON_CNT_B(MON_CNT_B)
    );

    always #5 CK = ~CK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int ch; logic sel; logic to; } ack_t;
    typedef struct { logic [NCH*CW-1:0] a; logic [NCH*CW-1:0] b; } mon_t;

    ack_t ack_q[$];
    mon_t mon_q[$];

    int             cyc = 0;
    logic [NCH-1:0] hp [HLEN];
    logic [NCH-1:0] hn [HLEN];
    logic [NCH-1:0] m_sel, m_to, m_pend, m_pval, m_ack;
    int             m_deadline [NCH];
    int             m_mstate, m_mstart, m_mcnt;
    logic           m_mdone;
    logic           prev_ck = 1'b0;
    logic           prev_nrst = 1'b0;
    logic           prev_done = 1'b0;
    int             mode [NCH];

    function automatic logic [NCH-1:0] hpos(input int k);
        if (k < 0) return '0;
        return hp[k % HLEN];
    endfunction

    function automatic logic [NCH-1:0] hneg(input int k);
        if (k < 0) return '0;
        return hn[k % HLEN];
    endfunction

    task automatic model_reset(input bit wipe);
        if (wipe) begin
            for (int k = 0; k < HLEN; k++) begin
                hp[k] = '0;
                hn[k] = '0;
            end
            ack_q.delete();
            mon_q.delete();
        end
        m_sel = '1; m_to = '0; m_pend = '0; m_pval = '0; m_ack = '0;
        m_mstate = 0; m_mcnt = 0; m_mstart = 0; m_mdone = 1'b0;
    endtask

    task automatic pos_step();
        logic [NCH-1:0] dp, dn, ta, tb2;
        ack_t r;
        mon_t mr;
        int a, b;
        cyc++;
        if (!NRST) begin
            hp[cyc % HLEN] = '0;
            model_reset(1'b0);
            return;
        end
        hp[cyc % HLEN] = D;
        dp = hpos(cyc - 1);
        dn = hneg(cyc - 1);
        m_ack = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!m_pend[i]) begin
                if (POL_REQ[i]) begin
                    m_to[i] = 1'b0;
                    if (POLARITY[i] == m_sel[i]) m_ack[i] = 1'b1;
                    else begin
                        m_pend[i] = 1'b1;
                        m_pval[i] = POLARITY[i];
                        m_deadline[i] = cyc + TO_CYC;
                    end
                end
            end else begin
                if (POL_REQ[i]) begin
                    m_pval[i] = POLARITY[i];
                    m_deadline[i] = cyc + TO_CYC;
                    m_to[i] = 1'b0;
                end
                if (!dp[i] && !dn[i]) begin
                    m_sel[i] = m_pval[i]; m_ack[i] = 1'b1; m_pend[i] = 1'b0;
                end else if (cyc == m_deadline[i]) begin
                    m_sel[i] = m_pval[i]; m_ack[i] = 1'b1; m_pend[i] = 1'b0; m_to[i] = 1'b1;
                end
            end
            if (m_ack[i]) begin
                r.ch = i; r.sel = m_sel[i]; r.to = m_to[i];
                ack_q.push_back(r);
            end
        end
        if (m_mstate == 1) begin
            m_mcnt++;
            if (m_mcnt == WIN) begin
                // A: negedge sample k-1 vs posedge sample k; B: posedge k vs negedge k.
                for (int i = 0; i < NCH; i++) begin
                    a = 0; b = 0;
                    for (int k = m_mstart; k < m_mstart + WIN; k++) begin
                        ta = hpos(k) ^ hneg(k - 1);
                        a += int'(ta[i]);
                    end
                    for (int k = m_mstart - 1; k < m_mstart + WIN - 1; k++) begin
                        tb2 = hpos(k) ^ hneg(k);
                        b += int'(tb2[i]);
                    end
                    mr.a[i*CW +: CW] = CW'(a);
                    mr.b[i*CW +: CW] = CW'(b);
                end
                mon_q.push_back(mr);
                m_mdone = 1'b1;
                m_mstate = 2;
            end
        end else if (MON_START) begin
            m_mstate = 1; m_mcnt = 0; m_mstart = cyc; m_mdone = 1'b0;
        end
    endtask

    initial begin
        model_reset(1'b1);
        forever begin
            @(posedge CK or negedge CK or negedge NRST);
            if (CK !== prev_ck) begin
                prev_ck = CK;
                if (CK) pos_step();
                else    hn[cyc % HLEN] = NRST ? D : '0;
            end else if (prev_nrst && !NRST) begin
                model_reset(1'b1);
            end
            prev_nrst = NRST;
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        ack_t r;
        mon_t mr;
        forever begin
            @(posedge CK); #3;
            chk("out_pos", OUT, (m_sel & hpos(cyc)) | (~m_sel & hneg(cyc - 1)));
            chk("sel", SEL, m_sel);
            chk("pol_ack", POL_ACK, m_ack);
            chk("pol_to", POL_TO, m_to);
            chk("mon_done", MON_DONE, m_mdone);
            for (int i = 0; i < NCH; i++) begin
                if (POL_ACK[i]) begin
                    if (ack_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected: ch %0d acked, none expected (t=%0t)", i, $time);
                    end else begin
                        r = ack_q.pop_front();
                        chk("ack_ch", i, r.ch);
                        chk("ack_sel", SEL[i], r.sel);
                        chk("ack_to", POL_TO[i], r.to);
                    end
                end
            end
            if (MON_DONE && !prev_done) begin
                if (mon_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mon_unexpected: MON_DONE rose, no window expected (t=%0t)", $time);
                end else begin
                    mr = mon_q.pop_front();
                    chk("mon_cnt_a", MON_CNT_A, mr.a);
                    chk("mon_cnt_b", MON_CNT_B, mr.b);
                end
            end
            prev_done = MON_DONE;
            @(negedge CK); #3;
            chk("out_neg", OUT, (m_sel & hpos(cyc)) | (~m_sel & hneg(cyc)));
        end
    end

    // ---------------- D driver: changes 1 ns after each edge ----------------
    // mode: 0 hold, 1 random, 2 toggle after negedge, 3 toggle after posedge, 4 div8, 5 high, 6 low
    initial begin
        forever begin
            @(posedge CK); #1;
            for (int i = 0; i < NCH; i++) begin
                case (mode[i])
                    1: if ($urandom_range(0, 3) == 0) D[i] = ~D[i];
                    3: D[i] = ~D[i];
                    4: if (cyc % 4 == 0) D[i] = ~D[i];
                    5: D[i] = 1'b1;
                    6: D[i] = 1'b0;
                    default: ;
                endcase
            end
            @(negedge CK); #1;
            for (int i = 0; i < NCH; i++) begin
                case (mode[i])
                    1: if ($urandom_range(0, 3) == 0) D[i] = ~D[i];
                    2: D[i] = ~D[i];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus (all changes at posedge + 2) ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CK);
        #2;
    endtask

    task automatic req(input int ch, input logic pol);
        POLARITY[ch] = pol;
        POL_REQ[ch]  = 1'b1;
        wait_cyc(1);
        POL_REQ = '0;
    endtask

    task automatic mon_start();
        MON_START = 1'b1;
        wait_cyc(1);
        MON_START = 1'b0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < NCH; i++) mode[i] = 1;
        wait_cyc(6);
        chk("rst_sel", SEL, 4'hF);
        chk("rst_out", OUT, 4'h0);
        chk("rst_mon_done", MON_DONE, 1'b0);
        NRST = 1'b1;
        wait_cyc(10);

        // Switch on a divided clock: flip happens in the low phase.
        mode[0] = 4;
        guard = 0;
        while (D[0] !== 1'b1 && guard < 16) begin
            wait_cyc(1);
            guard++;
        end
        chk("div_high_seen", D[0], 1'b1);
        req(0, 1'b0);
        wait_cyc(20);
        chk("switch_sel0", SEL[0], 1'b0);
        chk("switch_to0", POL_TO[0], 1'b0);

        // Same-value request acks next cycle.
        mode[1] = 5;
        req(1, 1'b1);
        chk("same_ack1", POL_ACK[1], 1'b1);
        chk("same_sel1", SEL[1], 1'b1);

        // Timeout: D held high, no safe point ever.
        mode[2] = 5;
        wait_cyc(2);
        req(2, 1'b0);
        wait_cyc(TO_CYC - 1);
        chk("to_not_yet", SEL[2], 1'b1);
        wait_cyc(1);
        chk("to_sel2", SEL[2], 1'b0);
        chk("to_flag2", POL_TO[2], 1'b1);
        wait_cyc(2);
        req(2, 1'b0);
        chk("to_cleared2", POL_TO[2], 1'b0);

        // Monitor: toggles after negedge -> all A; after posedge -> all B.
        mode[3] = 2;
        wait_cyc(4);
        mon_start();
        wait_cyc(WIN + 2);
        chk("mon_neg_done", MON_DONE, 1'b1);
        chk("mon_neg_a3", MON_CNT_A[3*CW +: CW], 64);
        chk("mon_neg_b3", MON_CNT_B[3*CW +: CW], 0);
        mode[3] = 3;
        wait_cyc(4);
        mon_start();
        wait_cyc(WIN + 2);
        chk("mon_pos_done", MON_DONE, 1'b1);
        chk("mon_pos_a3", MON_CNT_A[3*CW +: CW], 0);
        chk("mon_pos_b3", MON_CNT_B[3*CW +: CW], 64);

        // Reset while a switch is pending and a window is running.
        mode[0] = 5;
        wait_cyc(2);
        req(0, 1'b1);
        mon_start();
        wait_cyc(3);
        NRST = 1'b0;
        #1;
        chk("mid_rst_sel", SEL, 4'hF);
        chk("mid_rst_ack", POL_ACK, 4'h0);
        chk("mid_rst_to", POL_TO, 4'h0);
        chk("mid_rst_done", MON_DONE, 1'b0);
        chk("mid_rst_out", OUT, 4'h0);
        wait_cyc(3);
        NRST = 1'b1;
        wait_cyc(20);

        // Randomised traffic.
        for (int i = 0; i < NCH; i++) mode[i] = 1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) mode[$urandom_range(0, NCH-1)] = int'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) begin
                POLARITY = NCH'($urandom);
                POL_REQ  = NCH'($urandom);
            end
            if ($urandom_range(0, 19) == 0) MON_START = 1'b1;
            if ($urandom_range(0, 399) == 0) NRST = 1'b0;
            wait_cyc(1);
            POL_REQ = '0;
            MON_START = 1'b0;
            NRST = 1'b1;
        end
        wait_cyc(WIN + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
